fail_addr_logger: RTL

- Sits directly downstream of mbist; consumes its error, address_0, complete and force_terminate outputs during a self-test run.
- Edge-detects each error event and masks the failing address to the width of the selected memtype.
- Buffers distinct failing addresses in a small FIFO and counts all failure events.
- Exposes the logged addresses afterwards through a valid/ready read port for a host or scan-out block.

---
 rtl/mbist_pkg.sv | 20 ++
 rtl/fail_fifo.sv | 55 +++++
 rtl/fail_addr_logger.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: types and helpers shared by the mbist fail-address logging slice.
//   state_t             - logger FSM states (fixed encodings, legacy-compatible)
//   memtype_addr_width  - memtype[4:2] -> significant address width (9..16)
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int unsigned ADDR_W_BASE = 9;

    // Address width selected by the memtype width field (memtype[4:2]).
    function automatic int unsigned memtype_addr_width(input logic [2:0] width_sel);
        return ADDR_W_BASE + 32'(width_sel);
    endfunction

endpackage

// File: rtl/fail_fifo.sv
// fail_fifo: synchronous single-clock FIFO holding logged failing addresses.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset (empties the FIFO)
//   clr          - synchronous flush (used when the logger re-arms)
//   push, din    - write request and data; ignored when full unless popping
//   pop          - read request; ignored when empty
//   dout         - head entry, zero when empty
//   full, empty  - occupancy flags
module fail_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/fail_addr_logger.sv
// fail_addr_logger: captures failing addresses reported by mbist during a
// self-test run and exposes them afterwards through a valid/ready port.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   test_mode         - host configuration window; arms/re-arms the logger
//   memtype           - memory type; [4:2] selects the address width (9..16)
//   error, address    - mbist error flag and address_0
//   complete          - mbist run finished
//   force_terminate   - mbist run aborted (sets aborted)
//   rd_ready          - consumer accepts rd_addr
//   rd_valid, rd_addr - head of the failing-address FIFO
//   fail_count        - saturating count of error rising edges in CAPTURE
//   overflow          - sticky: an entry was dropped on a full FIFO
//   aborted           - sticky: run ended via force_terminate
//   log_done          - high in DONE
import mbist_pkg::*;

module fail_addr_logger #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_mode,
    input  logic [4:0]            memtype,
    input  logic                  error,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  complete,
    input  logic                  force_terminate,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  overflow,
    output logic                  aborted,
    output logic                  log_done
);

    state_t                state;
    state_t                state_nx;
    logic                  enter_armed;
    logic                  error_q;
    logic                  event_hit;
    logic                  is_dup;
    int unsigned           addr_w;
    logic [ADDR_WIDTH-1:0] masked;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  last_valid;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] fifo_dout;
    logic                  unused_memtype_lo;

    assign unused_memtype_lo = ^memtype[1:0];

    // Next-state logic; re-arming from any state clears the capture context.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (test_mode) state_nx = ARMED;
            ARMED:   if (!test_mode) state_nx = CAPTURE;
            CAPTURE: begin
                if (test_mode)                        state_nx = ARMED;
                else if (complete || force_terminate) state_nx = DONE;
            end
            DONE:    if (test_mode) state_nx = ARMED;
            default: state_nx = IDLE;
        endcase
        enter_armed = (state_nx == ARMED) && (state != ARMED);
    end

    // Keep only the low addr_w bits of the live address.
    always_comb begin
        masked = '0;
        addr_w = memtype_addr_width(memtype[4:2]);
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
            masked[i] = address[i] & (i < addr_w);
        end
    end

    // A capture-cycle edge that coincides with re-arming is discarded by the clear.
    assign event_hit = error && !error_q && (state == CAPTURE) && !enter_armed;
    assign is_dup    = last_valid && (masked == last_addr);
    assign fifo_push = event_hit && !is_dup;
    assign fifo_pop  = rd_ready && !fifo_empty && (state != IDLE);
    assign drop      = fifo_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            error_q    <= 1'b0;
            fail_count <= '0;
            overflow   <= 1'b0;
            aborted    <= 1'b0;
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            error_q <= error;
            if (enter_armed) begin
                fail_count <= '0;
                overflow   <= 1'b0;
                aborted    <= 1'b0;
                last_addr  <= '0;
                last_valid <= 1'b0;
            end else begin
                if (event_hit) begin
                    if (fail_count != '1) fail_count <= fail_count + 1'b1;
                    // last_addr tracks the most recent distinct address even if dropped.
                    if (!is_dup) begin
                        last_addr  <= masked;
                        last_valid <= 1'b1;
                    end
                    if (drop) overflow <= 1'b1;
                end
                if (state == CAPTURE && state_nx == DONE && force_terminate) aborted <= 1'b1;
            end
        end
    end

    fail_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (enter_armed),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (masked),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid = !fifo_empty && (state != IDLE);
    assign rd_addr  = rd_valid ? fifo_dout : '0;
    assign log_done = (state == DONE);

endmodule
